// File: rtl/ram_burst_ctrl_if.sv
// Bus bundle between a burst requester and ram_burst_ctrl.
// It also carries the RAM pins that the controller drives.
// slave  : the controller's view.
// master : the system's view, meaning the requester plus the RAM's Dout.
interface ram_burst_ctrl_if #(
    parameter int AW = 8,
    parameter int DW = 8,
    parameter int LW = 5
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [LW-1:0] req_len;
    logic [DW-1:0] wr_data;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          done;
    logic          err;
    logic [DW-1:0] ram_din;
    logic [AW-1:0] ram_addr;
    logic          ram_en;
    logic          ram_we;
    logic [DW-1:0] ram_dout;

    modport slave (
        input  req_valid, req_we, req_addr, req_len, wr_data, wr_valid, ram_dout,
        output req_ready, wr_ready, rd_data, rd_valid, done, err,
               ram_din, ram_addr, ram_en, ram_we
    );

    modport master (
        output req_valid, req_we, req_addr, req_len, wr_data, wr_valid, ram_dout,
        input  req_ready, wr_ready, rd_data, rd_valid, done, err,
               ram_din, ram_addr, ram_en, ram_we
    );
endinterface

// File: rtl/ram_burst_ctrl.sv
// Burst access controller in front of a synchronous single-port RAM.
// It takes one read or write burst at a time and then walks the address
// sequentially, one beat per cycle.
// Optional macro RAM_ADDR_WRAP_EN changes how a burst that crosses the top
// address is handled:
//   - defined:   the burst wraps to address 0 and continues.
//   - undefined: the request is rejected with an err pulse.
module ram_burst_ctrl #(
    parameter int AW = 8,
    parameter int DW = 8,
    parameter int LW = 5
) (
    input  logic            CLK,
    input  logic            RST_N,
    ram_burst_ctrl_if.slave bus
);

    localparam int            MAX_BEATS = 2 ** (LW - 1);
    localparam logic [LW-1:0] MAX_LEN   = LW'(MAX_BEATS);
    localparam logic [AW:0]   ADDR_TOP  = (AW + 1)'(2 ** AW);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    state_t        state_r, state_n;
    logic [AW-1:0] cur_addr_r, cur_addr_n;
    logic [LW-1:0] remaining_r, remaining_n;
    logic          rd_valid_r;
    logic          err_r;

    logic [LW-1:0] len_eff_s;
    logic [AW:0]   end_sum_s;
    logic          cross_s;
    logic          reject_s;
    logic          req_ready_s;
    logic          wr_ready_s;
    logic          done_s;
    logic          ram_en_s;
    logic          ram_we_s;
    logic [AW-1:0] ram_addr_s;
    logic [DW-1:0] ram_din_s;

    // Clamp the requested length and detect a burst that runs past the top address.
    always_comb begin
        if (bus.req_len > MAX_LEN) begin
            len_eff_s = MAX_LEN;
        end else begin
            len_eff_s = bus.req_len;
        end
        // The exclusive end address is compared with 2**AW, so a zero-length
        // request can never look like a crossing.
        end_sum_s = {1'b0, bus.req_addr} + (AW + 1)'(len_eff_s);
`ifdef RAM_ADDR_WRAP_EN
        cross_s = 1'b0;
`else
        cross_s = (len_eff_s != {LW{1'b0}}) && (end_sum_s > ADDR_TOP);
`endif
    end

    // Next-state logic, next address and count, and the combinational RAM pin drive.
    always_comb begin
        state_n     = state_r;
        cur_addr_n  = cur_addr_r;
        remaining_n = remaining_r;
        reject_s    = 1'b0;
        req_ready_s = 1'b0;
        wr_ready_s  = 1'b0;
        done_s      = 1'b0;
        ram_en_s    = 1'b0;
        ram_we_s    = 1'b0;
        ram_addr_s  = {AW{1'b0}};
        ram_din_s   = {DW{1'b0}};
        case (state_r)
            ST_IDLE: begin
                req_ready_s = 1'b1;
                if (bus.req_valid) begin
                    if (cross_s) begin
                        reject_s = 1'b1;
                    end else begin
                        cur_addr_n  = bus.req_addr;
                        remaining_n = len_eff_s;
                        if (len_eff_s == {LW{1'b0}}) begin
                            state_n = ST_FIN;
                        end else if (bus.req_we) begin
                            state_n = ST_WR;
                        end else begin
                            state_n = ST_RD;
                        end
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_WR: begin
                wr_ready_s = 1'b1;
                if (bus.wr_valid) begin
                    ram_en_s    = 1'b1;
                    ram_we_s    = 1'b1;
                    ram_addr_s  = cur_addr_r;
                    ram_din_s   = bus.wr_data;
                    cur_addr_n  = cur_addr_r + AW'(1);
                    remaining_n = remaining_r - LW'(1);
                    if (remaining_r == LW'(1)) begin
                        state_n = ST_FIN;
                    end else begin
                        state_n = ST_WR;
                    end
                end else begin
                    state_n = ST_WR;
                end
            end
            ST_RD: begin
                ram_en_s    = 1'b1;
                ram_addr_s  = cur_addr_r;
                cur_addr_n  = cur_addr_r + AW'(1);
                remaining_n = remaining_r - LW'(1);
                if (remaining_r == LW'(1)) begin
                    state_n = ST_FIN;
                end else begin
                    state_n = ST_RD;
                end
            end
            ST_FIN: begin
                done_s  = 1'b1;
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State, current address and remaining beat count.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r     <= ST_IDLE;
            cur_addr_r  <= {AW{1'b0}};
            remaining_r <= {LW{1'b0}};
        end else begin
            state_r     <= state_n;
            cur_addr_r  <= cur_addr_n;
            remaining_r <= remaining_n;
        end
    end

    // Read-valid follows each read issue by one cycle, matching the RAM's
    // registered Dout. err marks the cycle after a rejected request.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_valid_r <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            rd_valid_r <= (state_r == ST_RD);
            err_r      <= reject_s;
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.wr_ready  = wr_ready_s;
    assign bus.done      = done_s;
    assign bus.err       = err_r;
    assign bus.rd_valid  = rd_valid_r;
    assign bus.rd_data   = bus.ram_dout;
    assign bus.ram_en    = ram_en_s;
    assign bus.ram_we    = ram_we_s;
    assign bus.ram_addr  = ram_addr_s;
    assign bus.ram_din   = ram_din_s;

endmodule
